mcl_host_req_scheduler: RTL and testbench

- Shares the single 128-bit host-to-manycore request link among num_req_p host-side requesters, for example the AXI-Lite TX FIFO path and a DMA-style engine.
- Arbitrates round-robin and meters issue against the endpoint's request credit budget (HOST_REQ_CREDITS).
- Provides a fence operation that blocks new issue until every outstanding request's credit has returned.
- Sits between the requester FIFOs and the manycore endpoint link.

---
 rtl/mcl_host_req_scheduler.sv | 137 +++++++++++++
 tb/tb_mcl_host_req_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcl_host_req_scheduler.sv
// Round-robin scheduler that shares one host request link among several requesters,
// metering issue against the endpoint's credit budget and supporting a drain fence.
module mcl_host_req_scheduler #(
    parameter int num_req_p       = 2,
    parameter int data_width_p    = 128,
    parameter int max_credits_p   = 32,
    parameter int credit_width_lp = $clog2(max_credits_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]              req_yumi_o,
    output logic                              link_v_o,
    output logic [data_width_p-1:0]           link_data_o,
    input  logic                              link_ready_i,
    input  logic                              credit_return_i,
    input  logic                              fence_i,
    output logic                              fence_done_o,
    output logic [credit_width_lp-1:0]        credits_o,
    output logic [$clog2(num_req_p)-1:0]      grant_id_o,
    output logic                              credit_overflow_o
);

    localparam int id_width_lp = $clog2(num_req_p);
    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_credits_p);
    localparam logic [id_width_lp-1:0]     last_id_lp     = id_width_lp'(num_req_p - 1);

    // Handshake: the link side transfers a packet on any cycle where link_v_o and
    // link_ready_i are both high; a requester's packet is taken when its yumi bit is high.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FENCE = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic                       link_v_q, link_v_d;
    logic [data_width_p-1:0]    link_data_q, link_data_d;
    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic [id_width_lp-1:0]     grant_id_q, grant_id_d;
    logic [id_width_lp-1:0]     rr_ptr_q, rr_ptr_d;
    logic                       fence_done_q, fence_done_d;
    logic                       overflow_q, overflow_d;

    logic                       slot_free;
    logic                       found;
    logic [id_width_lp-1:0]     winner;
    logic                       grant;
    int                         idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        // Search begins at the pointer and wraps, so the first valid at or after it wins.
        for (int i = 0; i < num_req_p; i++) begin
            idx = (int'(rr_ptr_q) + i) % num_req_p;
            if (!found && req_v_i[idx]) begin
                found  = 1'b1;
                winner = id_width_lp'(idx);
            end
        end

        slot_free = !link_v_q || link_ready_i;
        // Reset gating keeps yumi low during an asynchronous reset without waiting for an edge.
        grant = reset_n_i && (state_q == ST_RUN) && !fence_i && slot_free &&
                (credits_q != '0) && found;

        req_yumi_o = '0;
        if (grant) req_yumi_o[winner] = 1'b1;

        link_v_d    = link_v_q && !link_ready_i;
        link_data_d = link_data_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant) begin
            link_v_d    = 1'b1;
            link_data_d = req_data_i[int'(winner)*data_width_p +: data_width_p];
            grant_id_d  = winner;
            rr_ptr_d    = (winner == last_id_lp) ? '0 : winner + id_width_lp'(1);
        end

        credits_d  = credits_q;
        overflow_d = overflow_q;
        if (grant && !credit_return_i) begin
            credits_d = credits_q - credit_width_lp'(1);
        end else if (!grant && credit_return_i) begin
            if (credits_q == max_credits_lp) overflow_d = 1'b1;
            else credits_d = credits_q + credit_width_lp'(1);
        end

        state_d      = state_q;
        fence_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (fence_i) state_d = ST_FENCE;
            end
            ST_FENCE: begin
                if (credits_q == max_credits_lp && !link_v_q) begin
                    state_d      = ST_RUN;
                    fence_done_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_RUN;
            link_v_q     <= 1'b0;
            link_data_q  <= '0;
            credits_q    <= max_credits_lp;
            grant_id_q   <= last_id_lp;
            rr_ptr_q     <= '0;
            fence_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            link_v_q     <= link_v_d;
            link_data_q  <= link_data_d;
            credits_q    <= credits_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            fence_done_q <= fence_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign link_v_o          = link_v_q;
    assign link_data_o       = link_data_q;
    assign credits_o         = credits_q;
    assign grant_id_o        = grant_id_q;
    assign fence_done_o      = fence_done_q;
    assign credit_overflow_o = overflow_q;

endmodule

// File: tb/tb_mcl_host_req_scheduler.sv
// Randomized bench for mcl_host_req_scheduler: per-cycle reference model with a packet
// queue for the link register, plus directed phases for credits, fence and reset.
module tb_mcl_host_req_scheduler;

    localparam int N    = 2;
    localparam int W    = 128;
    localparam int MAXC = 32;
    localparam int CW   = $clog2(MAXC + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_v_i = '0;
    logic [N*W-1:0]   req_data_i = '0;
    logic [N-1:0]     req_yumi_o;
    logic             link_v_o;
    logic [W-1:0]     link_data_o;
    logic             link_ready_i = 1'b0;
    logic             credit_return_i = 1'b0;
    logic             fence_i = 1'b0;
    logic             fence_done_o;
    logic [CW-1:0]    credits_o;
    logic [$clog2(N)-1:0] grant_id_o;
    logic             credit_overflow_o;

    mcl_host_req_scheduler #(
        .num_req_p(N), .data_width_p(W), .max_credits_p(MAXC)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .req_v_i(req_v_i), .req_data_i(req_data_i),
        .req_yumi_o(req_yumi_o), .link_v_o(link_v_o), .link_data_o(link_data_o),
        .link_ready_i(link_ready_i), .credit_return_i(credit_return_i), .fence_i(fence_i),
        .fence_done_o(fence_done_o), .credits_o(credits_o), .grant_id_o(grant_id_o),
        .credit_overflow_o(credit_overflow_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] exp_q[$];
    int           m_credits;
    int           m_ptr;
    int           m_id;
    bit           m_fence;
    bit           m_done;
    bit           m_ovf;
    bit           pend[N];
    logic [W-1:0] pdata[N];

    // Stimulus knobs
    logic [N-1:0] req_en = '0;
    int p_req = 100, p_ready = 100, p_ret = 0, p_fence = 0, ret_mode = 0;
    int dut_grants = 0, done_seen = 0;

    task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_credits = MAXC;
        m_ptr     = 0;
        m_id      = N - 1;
        m_fence   = 1'b0;
        m_done    = 1'b0;
        m_ovf     = 1'b0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        bit           lv, slot, gnt, ret;
        int           w, outstanding;
        logic [N-1:0] exp_yumi;

        lv = (exp_q.size() != 0);
        check_val("link_v", W'(link_v_o), W'(lv));
        if (lv) check_val("link_data", link_data_o, exp_q[0]);
        check_val("credits", W'(credits_o), W'(m_credits));
        check_val("grant_id", W'(grant_id_o), W'(m_id));
        check_val("fence_done", W'(fence_done_o), W'(m_done));
        check_val("overflow", W'(credit_overflow_o), W'(m_ovf));
        if (fence_done_o) done_seen++;

        for (int i = 0; i < N; i++) begin
            if (!pend[i] && req_en[i] && $urandom_range(99) < p_req) begin
                pend[i]  = 1'b1;
                pdata[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            req_v_i[i]          = pend[i];
            req_data_i[i*W +: W] = pdata[i];
        end
        link_ready_i = ($urandom_range(99) < p_ready);
        outstanding  = MAXC - m_credits;
        case (ret_mode)
            1:       ret = (outstanding > 0) && ($urandom_range(99) < p_ret);
            2:       ret = (outstanding >= 2);
            3:       ret = 1'b1;
            default: ret = 1'b0;
        endcase
        credit_return_i = ret;
        fence_i = ($urandom_range(99) < p_fence);
        #1;

        slot = !lv || link_ready_i;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        gnt = !m_fence && !fence_i && slot && (m_credits > 0) && (w >= 0);
        exp_yumi = '0;
        if (gnt) exp_yumi[w] = 1'b1;
        check_val("yumi", W'(req_yumi_o), W'(exp_yumi));
        if (req_yumi_o != '0) dut_grants++;

        @(posedge clk);
        m_done = 1'b0;
        if (m_fence) begin
            if (m_credits == MAXC && !lv) begin
                m_fence = 1'b0;
                m_done  = 1'b1;
            end
        end else if (fence_i) begin
            m_fence = 1'b1;
        end
        if (lv && link_ready_i) void'(exp_q.pop_front());
        if (gnt) begin
            exp_q.push_back(pdata[w]);
            pend[w] = 1'b0;
            m_ptr   = (w + 1) % N;
            m_id    = w;
        end
        m_credits = m_credits - int'(gnt) + int'(ret);
        if (m_credits > MAXC) begin
            m_credits = MAXC;
            m_ovf     = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        req_en = '0; ret_mode = 1; p_ret = 100; p_ready = 100; p_fence = 0;
        run(40);
    endtask

    initial begin
        int g0, d0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_link_v", W'(link_v_o), W'(0));
        check_val("rst_link_data", link_data_o, W'(0));
        check_val("rst_credits", W'(credits_o), W'(MAXC));
        check_val("rst_grant_id", W'(grant_id_o), W'(N - 1));
        check_val("rst_overflow", W'(credit_overflow_o), W'(0));
        rst_n = 1'b1;

        // Both requesters saturating, credits returned two issues later
        req_en = '1; p_req = 100; p_ready = 100; ret_mode = 2;
        run(20);
        check_val("steady_credits", W'(credits_o), W'(30));

        // Credit exhaustion from requester 1 alone
        drain();
        req_en = 2'b10; ret_mode = 0; g0 = dut_grants;
        run(40);
        check_val("exhaust_grants", W'(dut_grants - g0), W'(32));
        check_val("exhaust_credits", W'(credits_o), W'(0));
        check_val("exhaust_link_v", W'(link_v_o), W'(0));
        check_val("exhaust_yumi", W'(req_yumi_o), W'(0));
        ret_mode = 3; run(1);
        ret_mode = 0; run(3);

        // Link back-pressure
        drain();
        req_en = '1; ret_mode = 1; p_ret = 50; p_ready = 0;
        run(6);
        p_ready = 100;
        run(6);

        // Fence with three packets in flight
        drain();
        req_en = '1; ret_mode = 0; d0 = done_seen;
        run(3);
        p_fence = 100; run(1);
        p_fence = 0; ret_mode = 1; p_ret = 50;
        run(10);
        p_ret = 100;
        run(20);
        check_val("fence_done_count", W'(done_seen - d0), W'(1));

        // Grant and return in the same cycle
        drain();
        req_en = 2'b10; ret_mode = 0;
        run(27);
        ret_mode = 3; run(1);
        check_val("same_cycle_credits", W'(credits_o), W'(5));

        // Return at full credit saturates and sets the sticky flag
        drain();
        ret_mode = 3; run(1);
        check_val("ovf_credits", W'(credits_o), W'(MAXC));
        check_val("ovf_flag", W'(credit_overflow_o), W'(1));

        // Mixed random traffic
        req_en = '1; p_req = 60; p_ready = 70; ret_mode = 1; p_ret = 40; p_fence = 3;
        run(1500);

        // Asynchronous reset mid-burst
        drain();
        req_en = '1; p_req = 100; p_ready = 0; ret_mode = 0;
        run(3);
        check_val("pre_reset_link_v", W'(link_v_o), W'(1));
        #2 rst_n = 1'b0;
        #1;
        check_val("async_link_v", W'(link_v_o), W'(0));
        check_val("async_yumi", W'(req_yumi_o), W'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; p_ready = 100;
        run(1);
        check_val("post_reset_first", W'(grant_id_o), W'(0));
        run(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
